sim_exit_ctrl: RTL and testbench



---
 rtl/sim_exit_ctrl.sv | 149 ++++++++++++++
 tb/tb_sim_exit_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_ctrl.sv
// Run-control sequencer behind the exit decoder: boot delay, watchdog-guarded run, drain, sticky status.
// States: BOOT hold fetch off | RUN fetch on, count cycles | DRAIN flush traffic | DONE sticky result.
module sim_exit_ctrl #(
    parameter int unsigned BOOT_DELAY     = 16,
    parameter int unsigned DRAIN_CYCLES   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 exit_valid_i,
    input  logic                 exit_zero_i,
    output logic                 fetch_enable_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] run_cycles_o,
    output logic [1:0]           state_o
);

    localparam int unsigned BOOT_W  = $clog2(BOOT_DELAY + 1);
    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [BOOT_W-1:0]  BOOT_LAST  = BOOT_W'(BOOT_DELAY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    // A limit wider than the counter can never be reached, so the watchdog is compiled out.
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0) &&
                           ((64'(TIMEOUT_CYCLES) >> CNT_WIDTH) == 64'd0);
    localparam logic [CNT_WIDTH-1:0] WD_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [BOOT_W-1:0]    boot_cnt, boot_cnt_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_nxt;
    logic [CNT_WIDTH-1:0] run_cycles, run_cycles_nxt;
    logic [CNT_WIDTH-1:0] run_inc;
    logic                 wd_hit;
    logic                 result, result_nxt;
    logic                 timeout, timeout_nxt;
    logic                 fetch_en, fetch_en_nxt;
    logic                 done, done_nxt;
    logic                 pass, pass_nxt;
    logic                 fail, fail_nxt;

    // Saturating increment: a long run pins at all-ones instead of wrapping.
    assign run_inc = (&run_cycles) ? run_cycles : run_cycles + CNT_WIDTH'(1);
    assign wd_hit  = WD_EN && (run_inc == WD_LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_BOOT;
            boot_cnt   <= '0;
            drain_cnt  <= '0;
            run_cycles <= '0;
            result     <= 1'b0;
            timeout    <= 1'b0;
            fetch_en   <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nxt;
            boot_cnt   <= boot_cnt_nxt;
            drain_cnt  <= drain_cnt_nxt;
            run_cycles <= run_cycles_nxt;
            result     <= result_nxt;
            timeout    <= timeout_nxt;
            fetch_en   <= fetch_en_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            fail       <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        boot_cnt_nxt   = boot_cnt;
        drain_cnt_nxt  = drain_cnt;
        run_cycles_nxt = run_cycles;
        result_nxt     = result;
        timeout_nxt    = timeout;
        fetch_en_nxt   = fetch_en;
        done_nxt       = done;
        pass_nxt       = pass;
        fail_nxt       = fail;

        unique case (state)
            ST_BOOT: begin
                // Exit requests are ignored here; the sticky source re-presents them in RUN.
                boot_cnt_nxt = boot_cnt + BOOT_W'(1);
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt    = ST_RUN;
                    fetch_en_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                run_cycles_nxt = run_inc;
                if (exit_valid_i) begin
                    state_nxt     = ST_DRAIN;
                    result_nxt    = exit_zero_i;
                    fetch_en_nxt  = 1'b0;
                    drain_cnt_nxt = '0;
                end else if (wd_hit) begin
                    state_nxt     = ST_DRAIN;
                    result_nxt    = 1'b0;
                    timeout_nxt   = 1'b1;
                    fetch_en_nxt  = 1'b0;
                    drain_cnt_nxt = '0;
                end
            end

            ST_DRAIN: begin
                drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                    pass_nxt  = result & ~timeout;
                    fail_nxt  = ~(result & ~timeout);
                end
            end

            ST_DONE: begin
                state_nxt = ST_DONE;
            end

            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    assign fetch_enable_o = fetch_en;
    assign done_o         = done;
    assign pass_o         = pass;
    assign fail_o         = fail;
    assign timeout_o      = timeout;
    assign run_cycles_o   = run_cycles;
    assign state_o        = state;

endmodule

// File: tb/tb_sim_exit_ctrl.sv
// Scoreboard bench for sim_exit_ctrl: each scenario pushes its predicted outcome, a negedge
// monitor checks the per-cycle timeline and pops/compares the final status when done_o rises.
module tb_sim_exit_ctrl;

    localparam int BOOT  = 4;
    localparam int DRAIN = 3;
    localparam int TMO   = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exit_valid = 1'b0;
    logic        exit_zero = 1'b0;
    logic        idle_in = 1'b0;

    logic        fetch, done, pass, fail, tmo;
    logic [31:0] rc;
    logic [1:0]  st;

    logic        nw_fetch, nw_done, nw_pass, nw_fail, nw_tmo;
    logic [31:0] nw_rc;
    logic [1:0]  nw_st;

    logic        sa_fetch, sa_done, sa_pass, sa_fail, sa_tmo;
    logic [3:0]  sa_rc;
    logic [1:0]  sa_st;

    sim_exit_ctrl #(.BOOT_DELAY(BOOT), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .exit_valid_i(exit_valid), .exit_zero_i(exit_zero),
        .fetch_enable_o(fetch), .done_o(done), .pass_o(pass), .fail_o(fail),
        .timeout_o(tmo), .run_cycles_o(rc), .state_o(st));

    // Watchdog disabled.
    sim_exit_ctrl #(.BOOT_DELAY(BOOT), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(0), .CNT_WIDTH(32)) u_nowd (
        .clk_i(clk), .rst_ni(rst_n), .exit_valid_i(idle_in), .exit_zero_i(idle_in),
        .fetch_enable_o(nw_fetch), .done_o(nw_done), .pass_o(nw_pass), .fail_o(nw_fail),
        .timeout_o(nw_tmo), .run_cycles_o(nw_rc), .state_o(nw_st));

    // 4-bit counter with a limit it can never reach: saturates at 15, no timeout.
    sim_exit_ctrl #(.BOOT_DELAY(BOOT), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(20), .CNT_WIDTH(4)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .exit_valid_i(idle_in), .exit_zero_i(idle_in),
        .fetch_enable_o(sa_fetch), .done_o(sa_done), .pass_o(sa_pass), .fail_o(sa_fail),
        .timeout_o(sa_tmo), .run_cycles_o(sa_rc), .state_o(sa_st));

    always #5 clk = ~clk;

    typedef struct {
        int e;          // RUN cycles until the run ends
        bit to;         // watchdog expected to fire
        bit pass;
        int done_edge;  // edge count after reset release at which done_o rises
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   edges;
    bit   done_seen;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // Reference timeline: BOOT for edges < BOOT, RUN for the next e edges, DRAIN for DRAIN edges, then DONE.
    int     n, es, ef;
    longint er;
    bit     et;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_seen = 1'b0;
        end else begin
            if (q.size() > 0) begin
                cur = q[0];
                n   = edges;
                if (n < BOOT) begin
                    es = 0; ef = 0; er = 0;
                end else if (n < BOOT + cur.e) begin
                    es = 1; ef = 1; er = n - BOOT;
                end else if (n < cur.done_edge) begin
                    es = 2; ef = 0; er = cur.e;
                end else begin
                    es = 3; ef = 0; er = cur.e;
                end
                et = (n >= BOOT + cur.e) ? cur.to : 1'b0;
                check("state", st, es);
                check("fetch_enable", fetch, ef);
                check("run_cycles", rc, er);
                check("timeout", tmo, et);
                if (n < cur.done_edge) check("status_before_done", {done, pass, fail}, 0);
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = q.pop_front();
                    check("done_edge", edges, cur.done_edge);
                    check("final_run_cycles", rc, cur.e);
                    check("final_timeout", tmo, cur.to);
                    check("final_pass", pass, cur.pass);
                    check("final_fail", fail, !cur.pass);
                end
            end
        end
    end

    task automatic go_to(input int target);
        while (edges < target) @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {fetch, done, pass, fail, tmo, st, rc}, 0);
        exit_valid = 1'b0;
        exit_zero  = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_case(input int k, input bit zero, input bit boot_exit, input bit flip, input bit mid_rst);
        exp_t x;
        int   keff;
        bit   ex_ok;
        keff  = boot_exit ? 1 : k;
        ex_ok = (keff != 0) && (TMO == 0 || keff <= TMO);
        x.e         = ex_ok ? keff : TMO;
        x.to        = !ex_ok;
        x.pass      = ex_ok && zero;
        x.done_edge = BOOT + x.e + DRAIN;
        q.delete();
        exit_valid = boot_exit;
        exit_zero  = boot_exit ? zero : 1'b0;
        q.push_back(x);
        @(negedge clk);
        #2 rst_n = 1'b1;
        if (!boot_exit && k > 0) begin
            go_to(BOOT + k - 1);
            exit_valid = 1'b1;
            exit_zero  = zero;
        end
        if (flip) begin
            go_to(x.done_edge - 2);
            exit_zero = ~exit_zero;
        end
        if (mid_rst) begin
            go_to(x.done_edge - 2);
            apply_reset();
            q.delete();
            return;
        end
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        check("done_reached", done, 1);
        repeat (3) @(negedge clk);
        check("done_hold", {done, pass, fail, tmo, st, fetch}, {1'b1, x.pass, !x.pass, x.to, 2'd3, 1'b0});
        check("done_hold_run_cycles", rc, x.e);
        apply_reset();
    endtask

    initial begin
        #3 check("reset_state", {fetch, done, pass, fail, tmo, st, rc}, 0);

        run_case(20, 1'b1, 1'b0, 1'b0, 1'b0);
        run_case(20, 1'b0, 1'b0, 1'b1, 1'b0);
        run_case(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_case(100, 1'b1, 1'b0, 1'b0, 1'b0);
        run_case(101, 1'b1, 1'b0, 1'b0, 1'b0);
        run_case(99, 1'b0, 1'b0, 1'b0, 1'b0);
        run_case(0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_case(30, 1'b1, 1'b0, 1'b0, 1'b1);
        run_case(5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_case(1, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            run_case(int'($urandom_range(0, 115)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Long run: main DUT times out, watchdog-less and saturating instances keep running.
        begin
            exp_t x;
            x.e = TMO; x.to = 1'b1; x.pass = 1'b0; x.done_edge = BOOT + TMO + DRAIN;
            q.delete();
            q.push_back(x);
            @(negedge clk);
            #2 rst_n = 1'b1;
            go_to(BOOT + 10000);
            check("nowd_state", nw_st, 1);
            check("nowd_fetch", nw_fetch, 1);
            check("nowd_timeout", nw_tmo, 0);
            check("nowd_run_cycles", nw_rc, 10000);
            check("nowd_status", {nw_done, nw_pass, nw_fail}, 0);
            check("sat_run_cycles", sa_rc, 15);
            check("sat_state", sa_st, 1);
            check("sat_timeout", {sa_tmo, sa_done, sa_pass, sa_fail}, 0);
            check("sat_fetch", sa_fetch, 1);
            check("main_after_long", {done, fail, tmo, st}, {1'b1, 1'b1, 1'b1, 2'd3});
            check("scoreboard_drained", q.size(), 0);
            apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
